// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_mux
// Brief    : Two-digit common-segment display scanner. Snapshots both
//            digit patterns once per frame, shows digit a then digit b on a
//            shared segment bus with active-low anode enables, and inserts
//            all-off dead time between digits to suppress ghosting.
//            Optional blink feature: define SEG_SCAN_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_mux #(
    parameter int DIV         = 50000,  // cycles each digit is lit per frame
    parameter int BLANK_CYC   = 16,     // dead-time cycles between digits
    parameter int SEG_ACT_LOW = 1       // 1 = active-low segments
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 256    // frames per blink phase
`endif
) (
    input  logic       clk,
    input  logic       reset,
`ifdef SEG_SCAN_BLINK_EN
    input  logic       blink,
`endif
    input  logic [6:0] seg_a,
    input  logic [6:0] seg_b,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_start
);

    // Dwell counter must hold the larger of the two dwell lengths (min 2).
    localparam int C_DW_MAX = (DIV > BLANK_CYC) ? ((DIV > 2) ? DIV : 2)
                                                : ((BLANK_CYC > 2) ? BLANK_CYC : 2);
    localparam int CNT_W    = $clog2(C_DW_MAX);

    localparam logic [CNT_W-1:0] C_SHOW_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] C_BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    localparam logic [1:0] C_SHOW_A   = 2'd0;
    localparam logic [1:0] C_BLANK_AB = 2'd1;
    localparam logic [1:0] C_SHOW_B   = 2'd2;
    localparam logic [1:0] C_BLANK_BA = 2'd3;

    // Without dead time, reset lands directly on a SHOW_A entry.
    localparam logic [1:0] C_RST_STATE = (BLANK_CYC == 0) ? C_SHOW_A : C_BLANK_BA;
    localparam logic [6:0] C_ALL_OFF   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

`ifdef SEG_SCAN_BLINK_EN
    // Counter holds 1..BLINK_FRAMES once running; 0 only before the first frame.
    localparam int FC_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FC_W-1:0] C_FC_TOP = FC_W'(BLINK_FRAMES);
    localparam logic [FC_W-1:0] C_FC_RST = FC_W'((BLANK_CYC == 0) ? 1 : 0);
`endif

    // Map a logical pattern (1 = lit) onto the bus polarity.
    function automatic logic [6:0] pol(input logic [6:0] x);
        return (SEG_ACT_LOW != 0) ? ~x : x;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       lat_a_q, lat_a_d;
    logic [6:0]       lat_b_q, lat_b_d;
    logic [6:0]       seg_q, seg_d;
    logic [1:0]       an_q, an_d;
    logic             frame_start_q, frame_start_d;
    logic             w_last;
    logic             w_enter_a;
    logic             w_dark;
`ifdef SEG_SCAN_BLINK_EN
    logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic             phase_q, phase_d;
`endif

    // State, dwell counter, snapshot and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= C_RST_STATE;
            cnt_q         <= '0;
            lat_a_q       <= (BLANK_CYC == 0) ? seg_a : 7'h00;
            lat_b_q       <= (BLANK_CYC == 0) ? seg_b : 7'h00;
            an_q          <= (BLANK_CYC == 0) ? 2'b10 : 2'b11;
            seg_q         <= (BLANK_CYC == 0) ? pol(seg_a) : C_ALL_OFF;
            frame_start_q <= (BLANK_CYC == 0);
`ifdef SEG_SCAN_BLINK_EN
            frame_cnt_q   <= C_FC_RST;
            phase_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lat_a_q       <= lat_a_d;
            lat_b_q       <= lat_b_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
`ifdef SEG_SCAN_BLINK_EN
            frame_cnt_q   <= frame_cnt_d;
            phase_q       <= phase_d;
`endif
        end
    end

    // Next state: leave each state after its dwell, snapshot on SHOW_A entry.
    always_comb begin
        state_d = state_q;
        w_last  = 1'b0;
        case (state_q)
            C_SHOW_A: begin
                w_last = (cnt_q == C_SHOW_LAST);
                if (w_last) state_d = (BLANK_CYC == 0) ? C_SHOW_B : C_BLANK_AB;
            end
            C_BLANK_AB: begin
                w_last = (cnt_q == C_BLANK_LAST);
                if (w_last) state_d = C_SHOW_B;
            end
            C_SHOW_B: begin
                w_last = (cnt_q == C_SHOW_LAST);
                if (w_last) state_d = (BLANK_CYC == 0) ? C_SHOW_A : C_BLANK_BA;
            end
            default: begin
                w_last = (cnt_q == C_BLANK_LAST);
                if (w_last) state_d = C_SHOW_A;
            end
        endcase

        cnt_d     = w_last ? '0 : cnt_q + 1'b1;
        w_enter_a = w_last && (state_d == C_SHOW_A);
        lat_a_d   = w_enter_a ? seg_a : lat_a_q;
        lat_b_d   = w_enter_a ? seg_b : lat_b_q;

`ifdef SEG_SCAN_BLINK_EN
        // The phase flips on the first SHOW_A entry after every
        // BLINK_FRAMES completed frames.
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (w_enter_a) begin
            if (frame_cnt_q == C_FC_TOP) begin
                frame_cnt_d = FC_W'(1);
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
`endif
    end

    // Output decode of the upcoming state so outputs stay in step with it.
    always_comb begin
        w_dark = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
        w_dark = blink && phase_d;
`endif
        an_d          = 2'b11;
        seg_d         = C_ALL_OFF;
        frame_start_d = w_enter_a;
        case (state_d)
            C_SHOW_A: begin
                if (!w_dark) begin
                    an_d  = 2'b10;
                    seg_d = pol(lat_a_d);
                end
            end
            C_SHOW_B: begin
                if (!w_dark) begin
                    an_d  = 2'b01;
                    seg_d = pol(lat_b_d);
                end
            end
            default: begin
                an_d  = 2'b11;
                seg_d = C_ALL_OFF;
            end
        endcase
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_mux
// Brief    : Scoreboard bench for seg_scan_mux. Four configurations run
//            side by side from shared random stimulus; a frame-position
//            model predicts every output cycle and a monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_mux;

    localparam int N = 4;
    localparam int CDIV [N] = '{4, 4, 4, 1};
    localparam int CBLK [N] = '{2, 0, 2, 1};
    localparam int CAL  [N] = '{1, 1, 0, 1};

    typedef logic [N-1:0][9:0] exp_t;   // per config {an, seg, frame_start}

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_a;
    logic [6:0] seg_b;
    logic [6:0] seg_o [N];
    logic [1:0] an_o  [N];
    logic       fs_o  [N];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(.DIV(4), .BLANK_CYC(2), .SEG_ACT_LOW(1)) u_dut0 (
        .clk(clk), .reset(reset), .seg_a(seg_a), .seg_b(seg_b),
        .seg(seg_o[0]), .an(an_o[0]), .frame_start(fs_o[0]));
    seg_scan_mux #(.DIV(4), .BLANK_CYC(0), .SEG_ACT_LOW(1)) u_dut1 (
        .clk(clk), .reset(reset), .seg_a(seg_a), .seg_b(seg_b),
        .seg(seg_o[1]), .an(an_o[1]), .frame_start(fs_o[1]));
    seg_scan_mux #(.DIV(4), .BLANK_CYC(2), .SEG_ACT_LOW(0)) u_dut2 (
        .clk(clk), .reset(reset), .seg_a(seg_a), .seg_b(seg_b),
        .seg(seg_o[2]), .an(an_o[2]), .frame_start(fs_o[2]));
    seg_scan_mux #(.DIV(1), .BLANK_CYC(1), .SEG_ACT_LOW(1)) u_dut3 (
        .clk(clk), .reset(reset), .seg_a(seg_a), .seg_b(seg_b),
        .seg(seg_o[3]), .an(an_o[3]), .frame_start(fs_o[3]));

    function automatic logic [6:0] pol(input int al, input logic [6:0] x);
        return (al != 0) ? ~x : x;
    endfunction

    // Reference: position p within the frame (0 = first SHOW_A cycle).
    exp_t       exp_q [$];
    int         p     [N];
    logic [6:0] la    [N];
    logic [6:0] lb    [N];
    bit         started = 1'b0;

    always @(posedge clk) begin : model
        exp_t       e;
        int         per;
        int         d;
        int         b;
        logic [6:0] off;
        if (reset) started = 1'b1;
        if (started) begin
            for (int i = 0; i < N; i++) begin
                d   = CDIV[i];
                b   = CBLK[i];
                per = 2 * d + 2 * b;
                off = (CAL[i] != 0) ? 7'h7F : 7'h00;
                if (reset) p[i] = (b == 0) ? 0 : per - b;
                else       p[i] = (p[i] + 1) % per;
                if (p[i] == 0) begin
                    la[i] = seg_a;
                    lb[i] = seg_b;
                end else if (reset) begin
                    la[i] = 7'h00;
                    lb[i] = 7'h00;
                end
                if (p[i] < d)
                    e[i] = {2'b10, pol(CAL[i], la[i]), (p[i] == 0)};
                else if (p[i] < d + b)
                    e[i] = {2'b11, off, 1'b0};
                else if (p[i] < 2 * d + b)
                    e[i] = {2'b01, pol(CAL[i], lb[i]), 1'b0};
                else
                    e[i] = {2'b11, off, 1'b0};
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: every cycle is an output cycle; compare away from the edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < N; i++) begin
                checks++;
                if ({an_o[i], seg_o[i], fs_o[i]} !== e[i]) begin
                    errors++;
                    $display("FAIL out_cfg%0d t=%0t: got an=%b seg=%b fs=%b, expected an=%b seg=%b fs=%b",
                             i, $time, an_o[i], seg_o[i], fs_o[i], e[i][9:8], e[i][7:1], e[i][0]);
                end
                checks++;
                if (an_o[i] === 2'b00) begin
                    errors++;
                    $display("FAIL both_anodes_cfg%0d t=%0t: got an=%b, expected not 00",
                             i, $time, an_o[i]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        seg_a = 7'b1111110;
        seg_b = 7'b0110000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Land in SHOW_B of the first frame for cfg0, then alter digit a.
        repeat (9) @(negedge clk);
        seg_a = 7'b0110011;
        repeat (30) @(negedge clk);
        // Random pattern changes and occasional one-cycle resets.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) seg_a = 7'($urandom);
            if ($urandom_range(3) == 0) seg_b = 7'($urandom);
            reset = ($urandom_range(59) == 0);
        end
        reset = 1'b0;
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
